// File: rtl/vbit_pkg.sv
// rtl/vbit_pkg.sv - shared opcode, element-width and sequencer state types
package vbit_pkg;

  typedef enum logic [4:0] {
    AND  = 5'd0,
    OR   = 5'd1,
    XOR  = 5'd2,
    NOT  = 5'd3,
    MINU = 5'd4,
    MIN  = 5'd5,
    MAXU = 5'd6,
    MAX  = 5'd7
  } vbit_op_e;

  typedef enum logic [1:0] {
    E8  = 2'd0,
    E16 = 2'd1,
    E32 = 2'd2
  } vsew_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAP   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/vector_bitwise_unit.sv
// rtl/vector_bitwise_unit.sv - combinational per-element bitwise/min/max over one VLEN beat
module vector_bitwise_unit
  import vbit_pkg::*;
#(
  parameter int VLEN = 32
) (
  input  logic [VLEN-1:0] dataA,
  input  logic [VLEN-1:0] dataB,
  input  logic [4:0]      bitwise_op,
  input  logic [1:0]      sew,
  output logic [VLEN-1:0] bitwise_result
);

  // One lane, zero-extended to 32 bits; signed compares flip the lane's sign bit
  // so a single unsigned comparator serves both flavours.
  function automatic logic [31:0] lane_op(
    input logic [4:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] sbit
  );
    logic lt_u;
    logic lt_s;
    lt_u = (a < b);
    lt_s = ((a ^ sbit) < (b ^ sbit));
    case (vbit_op_e'(op))
      AND:     lane_op = a & b;
      OR:      lane_op = a | b;
      XOR:     lane_op = a ^ b;
      NOT:     lane_op = ~a;
      MINU:    lane_op = lt_u ? a : b;
      MIN:     lane_op = lt_s ? a : b;
      MAXU:    lane_op = lt_u ? b : a;
      MAX:     lane_op = lt_s ? b : a;
      default: lane_op = '0;
    endcase
  endfunction

  // Split the beat into lanes of the selected width and apply the op per lane
  always_comb begin
    bitwise_result = '0;
    case (vsew_e'(sew))
      E8: begin
        for (int i = 0; i < VLEN / 8; i++) begin
          bitwise_result[i*8 +: 8] = 8'(lane_op(bitwise_op, 32'(dataA[i*8 +: 8]),
                                                32'(dataB[i*8 +: 8]), 32'h0000_0080));
        end
      end
      E16: begin
        for (int i = 0; i < VLEN / 16; i++) begin
          bitwise_result[i*16 +: 16] = 16'(lane_op(bitwise_op, 32'(dataA[i*16 +: 16]),
                                                   32'(dataB[i*16 +: 16]), 32'h0000_8000));
        end
      end
      E32: begin
        for (int i = 0; i < VLEN / 32; i++) begin
          bitwise_result[i*32 +: 32] = lane_op(bitwise_op, dataA[i*32 +: 32],
                                               dataB[i*32 +: 32], 32'h8000_0000);
        end
      end
      default: bitwise_result = '0;
    endcase
  end

endmodule

// File: rtl/vector_bitwise_seq.sv
// rtl/vector_bitwise_seq.sv - multi-beat VRF read/compute/write sequencer; option macro VBIT_SEQ_ERR_EN
module vector_bitwise_seq
  import vbit_pkg::*;
#(
  parameter  int VLEN     = 32,
  parameter  int LMUL_MAX = 8,
  localparam int IW       = (LMUL_MAX > 1) ? $clog2(LMUL_MAX) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [1:0]      in_sew,
  input  logic [1:0]      in_lmul,
  output logic            rd_req,
  output logic [IW-1:0]   rd_idx,
  input  logic [VLEN-1:0] rd_dataA,
  input  logic [VLEN-1:0] rd_dataB,
  output logic [VLEN-1:0] bu_dataA,
  output logic [VLEN-1:0] bu_dataB,
  output logic [4:0]      bu_op,
  output logic [1:0]      bu_sew,
  input  logic [VLEN-1:0] bu_result,
  output logic            wr_valid,
  input  logic            wr_ready,
  output logic [IW-1:0]   wr_idx,
  output logic [VLEN-1:0] wr_data,
  output logic            done,
`ifdef VBIT_SEQ_ERR_EN
  output logic            err,
`endif
  output logic            busy
);

  seq_state_e      r_state;
  logic [IW-1:0]   r_beat;
  logic [IW-1:0]   r_last;
  logic [VLEN-1:0] r_opA;
  logic [VLEN-1:0] r_opB;
  logic [4:0]      r_op;
  logic [1:0]      r_sew;
  logic            r_rd_req;
  logic            r_wr_valid;
  logic            r_done;
`ifdef VBIT_SEQ_ERR_EN
  logic            r_err;
`endif

  // Index of the final beat: 1<<lmul beats, clamped to what the index can address
  function automatic logic [IW-1:0] last_beat(input logic [1:0] lmul);
    int beats;
    beats = 1 << lmul;
    if (beats > LMUL_MAX) beats = LMUL_MAX;
    return IW'(beats - 1);
  endfunction

  // Sequencer FSM: state, beat counter, operand capture and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_last     <= '0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_op       <= '0;
      r_sew      <= '0;
      r_rd_req   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_done     <= 1'b0;
`ifdef VBIT_SEQ_ERR_EN
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op   <= in_op;
            r_sew  <= in_sew;
            r_last <= last_beat(in_lmul);
            r_beat <= '0;
`ifdef VBIT_SEQ_ERR_EN
            // Unsupported op or width: skip the VRF entirely and flag it
            if ((in_op > 5'd7) || (in_sew == 2'd3)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else
`endif
            begin
              r_state  <= READ;
              r_rd_req <= 1'b1;
            end
          end
        end
        READ: begin
          r_rd_req <= 1'b0;
          r_state  <= CAP;
        end
        CAP: begin
          r_opA      <= rd_dataA;
          r_opB      <= rd_dataB;
          r_wr_valid <= 1'b1;
          r_state    <= WRITE;
        end
        WRITE: begin
          if (wr_ready) begin
            r_wr_valid <= 1'b0;
            if (r_beat == r_last) begin
              // Counter stays on the last beat so it never wraps
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_beat   <= r_beat + 1'b1;
              r_state  <= READ;
              r_rd_req <= 1'b1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
`ifdef VBIT_SEQ_ERR_EN
          r_err   <= 1'b0;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign in_ready = (r_state == IDLE);
  assign rd_req   = r_rd_req;
  assign rd_idx   = r_beat;
  assign bu_dataA = r_opA;
  assign bu_dataB = r_opB;
  assign bu_op    = r_op;
  assign bu_sew   = r_sew;
  assign wr_valid = r_wr_valid;
  assign wr_idx   = r_beat;
  assign wr_data  = bu_result;
  assign done     = r_done;
`ifdef VBIT_SEQ_ERR_EN
  assign err      = r_err;
`endif

endmodule

// File: tb/tb_vector_bitwise_seq.sv
// tb/tb_vector_bitwise_seq.sv - scoreboard bench for vector_bitwise_seq with the real bitwise unit
module tb_vector_bitwise_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [1:0]  in_sew = '0;
  logic [1:0]  in_lmul = '0;
  logic        rd_req;
  logic [2:0]  rd_idx;
  logic [31:0] rd_dataA = '0;
  logic [31:0] rd_dataB = '0;
  logic [31:0] bu_dataA;
  logic [31:0] bu_dataB;
  logic [4:0]  bu_op;
  logic [1:0]  bu_sew;
  logic [31:0] bu_result;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic        done;
  logic        busy;
`ifdef VBIT_SEQ_ERR_EN
  logic        err;
  logic        err_at_done = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_at = -1;
  int rd_cnt = 0;
  int stall_left = 0;
  logic [2:0]  stall_idx = '0;
  logic        prev_stall = 1'b0;
  logic [2:0]  p_idx = '0;
  logic [31:0] p_data = '0;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] vrfA [0:7];
  logic [31:0] vrfB [0:7];

  vector_bitwise_seq #(.VLEN(32), .LMUL_MAX(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_sew(in_sew), .in_lmul(in_lmul),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_dataA(rd_dataA), .rd_dataB(rd_dataB),
    .bu_dataA(bu_dataA), .bu_dataB(bu_dataB), .bu_op(bu_op), .bu_sew(bu_sew),
    .bu_result(bu_result), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_data(wr_data), .done(done),
`ifdef VBIT_SEQ_ERR_EN
    .err(err),
`endif
    .busy(busy)
  );

  vector_bitwise_unit #(.VLEN(32)) u_bu (
    .dataA(bu_dataA), .dataB(bu_dataB), .bitwise_op(bu_op), .sew(bu_sew),
    .bitwise_result(bu_result)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // VRF model: data valid the cycle after rd_req, poison otherwise
  always @(posedge clk) begin
    if (rd_req) begin
      rd_dataA <= vrfA[rd_idx];
      rd_dataB <= vrfB[rd_idx];
    end else begin
      rd_dataA <= 32'hA5A5_A5A5;
      rd_dataB <= 32'h5A5A_5A5A;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference lane model written over integer lanes
  function automatic logic [31:0] model(input int op, input int sew,
                                        input logic [31:0] a, input logic [31:0] b);
    int w;
    logic [31:0] r;
    longint m, ea, eb, sa, sb, res;
    w = 8 << sew;
    r = '0;
    m = (longint'(1) << w) - 1;
    for (int l = 0; l < 32 / w; l++) begin
      ea = longint'(a >> (l * w)) & m;
      eb = longint'(b >> (l * w)) & m;
      sa = (ea >= (longint'(1) << (w - 1))) ? ea - (longint'(1) << w) : ea;
      sb = (eb >= (longint'(1) << (w - 1))) ? eb - (longint'(1) << w) : eb;
      case (op)
        0: res = ea & eb;
        1: res = ea | eb;
        2: res = ea ^ eb;
        3: res = ~ea & m;
        4: res = (ea < eb) ? ea : eb;
        5: res = (sa < sb) ? ea : eb;
        6: res = (ea > eb) ? ea : eb;
        7: res = (sa > sb) ? ea : eb;
        default: res = 0;
      endcase
      r = r | 32'(res << (l * w));
    end
    return r;
  endfunction

  // Write-side monitor: stall generator, hold checks, scoreboard pop, done capture
  always @(negedge clk) begin
    if (stall_left > 0 && wr_valid === 1'b1 && wr_idx == stall_idx) begin
      wr_ready = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      wr_ready = 1'b1;
    end
    if (prev_stall) begin
      chk("stall_hold_valid", wr_valid, 1);
      chk("stall_hold_idx", wr_idx, p_idx);
      chk("stall_hold_data", wr_data, p_data);
      chk("stall_no_rd_req", rd_req, 0);
    end
    prev_stall = (wr_valid === 1'b1) && !wr_ready;
    p_idx = wr_idx;
    p_data = wr_data;
    if (rd_req === 1'b1) rd_cnt++;
    if (wr_valid === 1'b1 && wr_ready) begin
      checks++;
      assert (sbq.size() > 0) else begin
        errors++;
        $error("FAIL sb_write_expected observed=write idx %0d expected=no write", wr_idx);
      end
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_idx", wr_idx, e.idx);
        chk("sb_data", wr_data, e.data);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_at = cyc - t0;
`ifdef VBIT_SEQ_ERR_EN
      err_at_done = err;
`endif
    end
  end

  task automatic issue(input logic [4:0] op, input logic [1:0] sew,
                       input logic [1:0] lmul, input bit hold);
    @(negedge clk); #1;
    chk("issue_in_ready", in_ready, 1);
    in_op = op;
    in_sew = sew;
    in_lmul = lmul;
    in_valid = 1'b1;
    t0 = cyc;
    done_cnt = 0;
    done_at = -1;
    rd_cnt = 0;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cycle);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt > 0) in_valid = 1'b0;
    chk({tag, "_done_seen"}, (done_cnt > 0), 1);
    chk({tag, "_done_cycle"}, done_at, exp_cycle);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_sb_empty"}, sbq.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_wr_valid"}, wr_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_bu_dataA"}, bu_dataA, 0);
    chk({tag, "_bu_dataB"}, bu_dataB, 0);
    chk({tag, "_bu_op"}, bu_op, 0);
    chk({tag, "_bu_sew"}, bu_sew, 0);
    chk({tag, "_wr_idx"}, wr_idx, 0);
    chk({tag, "_rd_idx"}, rd_idx, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin
      vrfA[i] = '0;
      vrfB[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk); #1;
    chk_reset("rst");

    // 1: e8 AND, single beat
    vrfA[0] = 32'h0403_0201;
    vrfB[0] = 32'hEDEE_EFF0;
    sbq.push_back('{3'd0, 32'h0402_0200});
    issue(5'd0, 2'd0, 2'd0, 1'b0);
    wait_done("t1_and", 4);

    // 2: e16 MAX and e32 MINU
    vrfA[0] = 32'h0065_0064;
    vrfB[0] = 32'h0033_0032;
    sbq.push_back('{3'd0, 32'h0065_0064});
    issue(5'd7, 2'd1, 2'd0, 1'b0);
    wait_done("t2_max16", 4);
    vrfA[0] = 32'h0000_00C8;
    vrfB[0] = 32'h0000_0096;
    sbq.push_back('{3'd0, 32'h0000_0096});
    issue(5'd4, 2'd2, 2'd0, 1'b0);
    wait_done("t2_minu32", 4);

    // 3: e8 XOR over 4 beats
    for (int i = 0; i < 4; i++) begin
      vrfA[i] = 32'(i);
      vrfB[i] = 32'hFFFF_FFFF;
      sbq.push_back('{3'(i), ~(32'(i))});
    end
    issue(5'd2, 2'd0, 2'd2, 1'b0);
    wait_done("t3_xor4", 13);

    // 4: 2-beat OR with 5-cycle stall on beat 1
    for (int i = 0; i < 2; i++) begin
      vrfA[i] = $urandom;
      vrfB[i] = $urandom;
      sbq.push_back('{3'(i), model(1, 0, vrfA[i], vrfB[i])});
    end
    stall_idx = 3'd1;
    stall_left = 5;
    issue(5'd1, 2'd0, 2'd1, 1'b0);
    wait_done("t4_stall", 12);
    chk("t4_stall_consumed", stall_left, 0);

    // Signed/unsigned min/max over several widths against the model
    for (int k = 0; k < 6; k++) begin
      vrfA[0] = $urandom;
      vrfB[0] = $urandom;
      sbq.push_back('{3'd0, model(4 + (k % 4), k % 3, vrfA[0], vrfB[0])});
      issue(5'(4 + (k % 4)), 2'(k % 3), 2'd0, 1'b0);
      wait_done("tm_minmax", 4);
    end

    // 5: reset during CAP of beat 2 of a 4-beat e16 XOR
    for (int i = 0; i < 4; i++) begin
      vrfA[i] = $urandom;
      vrfB[i] = $urandom;
      sbq.push_back('{3'(i), model(2, 1, vrfA[i], vrfB[i])});
    end
    issue(5'd2, 2'd1, 2'd2, 1'b0);
    n = 0;
    while ((cyc - t0) < 8 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t5_reached_cap", cyc - t0, 8);
    reset = 1'b1;
    @(negedge clk); #1;
    chk_reset("t5_rst");
    reset = 1'b0;
    sbq.delete();
    rd_cnt = 0;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_no_done", done_cnt, 0);
    chk("t5_no_rd", rd_cnt, 0);
    vrfA[0] = $urandom;
    vrfB[0] = $urandom;
    sbq.push_back('{3'd0, model(6, 0, vrfA[0], vrfB[0])});
    issue(5'd6, 2'd0, 2'd0, 1'b0);
    wait_done("t5_after", 4);

    // in_valid held high through the busy states: exactly one instruction
    vrfA[0] = $urandom;
    vrfB[0] = $urandom;
    sbq.push_back('{3'd0, model(3, 2, vrfA[0], vrfB[0])});
    issue(5'd3, 2'd2, 2'd0, 1'b1);
    wait_done("t6_hold", 4);

`ifdef VBIT_SEQ_ERR_EN
    // 6: rejected instructions bypass the VRF
    issue(5'd0, 2'd3, 2'd0, 1'b0);
    wait_done("t6_sew3", 1);
    chk("t6_sew3_rd", rd_cnt, 0);
    chk("t6_sew3_err", err_at_done, 1);
    issue(5'd9, 2'd0, 2'd0, 1'b0);
    wait_done("t6_op9", 1);
    chk("t6_op9_rd", rd_cnt, 0);
    chk("t6_op9_err", err_at_done, 1);
    chk("t6_err_clear", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
